conv3x3_merge_param: RTL and testbench
======================================

CONV3X3_MERGE_PARAM -- requirements
Module: conv3x3_merge_param

Interface
REQ-001 SHALL have parameter D, default 9, meaning square frame side in pixels (D >= 3).
REQ-002 SHALL have parameter DW, default 32, meaning signed two's-complement pixel/weight/output width.
REQ-003 SHALL have parameter CH, default 32, meaning number of input channels merged into one output.
REQ-004 SHALL have parameter STRIDE, default 1, meaning window step; legal values 1 and 2.
REQ-005 SHALL have parameter FRAC, default 0, meaning arithmetic right shift applied to the merged sum.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port valid_in, input, 1, meaning pxl_in carries one pixel per channel this cycle.
REQ-009 SHALL have port pxl_in, input, CH*DW, meaning channel c occupies bits [c*DW +: DW].
REQ-010 SHALL have port wgt_we, input, 1, meaning weight write strobe.
REQ-011 SHALL have port wgt_addr, input, clog2(9*CH), meaning weight index c*9 + 3*r + s (r = window row, 0 top; s = window column, 0 left).
REQ-012 SHALL have port wgt_data, input, DW, meaning signed weight value.
REQ-013 SHALL have port pxl_out, output, DW, meaning merged convolution result.
REQ-014 SHALL have port valid_out, output, 1, meaning pxl_out is valid this cycle.
REQ-015 SHALL have port frame_done, output, 1, meaning one-cycle pulse after the last pixel of a frame is accepted.
REQ-016 SHALL have port wgt_err, output, 1, meaning one-cycle pulse when a weight write is rejected.

Function
REQ-017 Pixels SHALL arrive in raster order; row/col counters advance only on valid_in = 1 and hold otherwise.
REQ-018 On acceptance of pixel (D-1, D-1), counters SHALL wrap to (0,0) and frame_done SHALL pulse on the following cycle.
REQ-019 Per channel, two line buffers of D entries plus a 3x3 shift window SHALL supply tap (r,s) = pixel (row-2+r, col-2+s).
REQ-020 A window SHALL fire when the accepted pixel has row >= 2, col >= 2, (row-2) mod STRIDE = 0, (col-2) mod STRIDE = 0.
REQ-021 Outputs per frame SHALL equal ((D-3)/STRIDE + 1)^2 (D=9: 49 for STRIDE 1, 16 for STRIDE 2), in raster order of firing.
REQ-022 Result SHALL be sum over all channels and 9 taps of pixel*weight, computed at full precision (2*DW + clog2(9*CH) bits).
REQ-023 Full sum SHALL be arithmetically shifted right by FRAC, then saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-024 Pipeline SHALL be 4 stages: products, per-channel 9-sum, cross-channel sum, shift/saturate register.
REQ-025 valid_out SHALL assert exactly 4 cycles after the firing pixel is accepted, independent of later valid_in gaps.
REQ-026 Pipeline SHALL advance every cycle; valid_in bubbles produce valid_out bubbles only.
REQ-027 wgt_we SHALL be honoured only when row = 0, col = 0, and no window is in flight.
REQ-028 wgt_we outside the REQ-027 condition SHALL be ignored, with wgt_err pulsing the next cycle.
REQ-029 Simultaneous wgt_we and valid_in at (0,0) SHALL accept the write; the new weight applies from the next frame.
REQ-030 pxl_out SHALL hold its last value while valid_out = 0.

Reset
REQ-031 On reset, counters, pipeline valid bits, pxl_out, valid_out, frame_done and wgt_err SHALL clear to 0 on the next edge.
REQ-032 Reset mid-frame SHALL discard in-flight windows; valid_out SHALL be 0 from the cycle after reset is sampled.
REQ-033 Weight storage SHALL be retained across reset; line-buffer contents are don't-care.

Verification
REQ-034 D=9, CH=2, STRIDE=1, all weights 1, all pixels 1, continuous valid -> 49 outputs of 18; first valid_out 4 cycles after pixel index 20; one frame_done.
REQ-035 STRIDE=2, ch0 centre weight 1 (others 0), pixel = raster index -> 16 outputs: 10,12,14,16,28,...,70.
REQ-036 REQ-034 stimulus with valid_in random 50% -> identical 49-value sequence, each 4 cycles after its firing pixel.
REQ-037 DW=8, CH=1, FRAC=0, weights 127, pixels 127 -> every output 127; pixels -128 -> every output -128.
REQ-038 Reset asserted after pixel 40, then a full new frame -> no valid_out until the new frame's pixel 20 + 4 cycles; exactly 49 outputs.
REQ-039 wgt_we mid-frame -> wgt_err pulse one cycle later; weights and outputs unchanged versus the run without the write.

Source files
------------

// File: rtl/conv3x3_merge_param.sv
// Multi-channel 3x3 convolution over a DxD raster stream with per-channel line buffers,
// cross-channel merge, arithmetic shift and saturation. Four-stage pipeline after the window.

module conv3x3_ch #(
  parameter int D  = 9,
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 acc_i,
  input  logic [CW-1:0]        col_i,
  input  logic [DW-1:0]        pxl_i,
  input  logic [8:0][DW-1:0]   wgt_i,
  output logic [2*DW+3:0]      sum_o
);
  logic [DW-1:0]          lb0_q [D];
  logic [DW-1:0]          lb1_q [D];
  logic [8:0][DW-1:0]     win_q;
  logic [8:0][2*DW-1:0]   prod_q;
  logic signed [2*DW+3:0] sum_d;

  // win_q[3r+s]: row r (0 = oldest line), column s (2 = newest)
  always_ff @(posedge clk) begin
    if (acc_i) begin
      lb0_q[col_i] <= pxl_i;
      lb1_q[col_i] <= lb0_q[col_i];
      for (int r = 0; r < 3; r++) begin
        win_q[3*r]   <= win_q[3*r+1];
        win_q[3*r+1] <= win_q[3*r+2];
      end
      win_q[2] <= lb1_q[col_i];
      win_q[5] <= lb0_q[col_i];
      win_q[8] <= pxl_i;
    end
    for (int i = 0; i < 9; i++)
      prod_q[i] <= (2*DW)'($signed(win_q[i])) * (2*DW)'($signed(wgt_i[i]));
    sum_o <= sum_d;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++)
      sum_d = sum_d + (2*DW+4)'($signed(prod_q[i]));
  end
endmodule

module conv3x3_merge_param #(
  parameter int D      = 9,
  parameter int DW     = 32,
  parameter int CH     = 32,
  parameter int STRIDE = 1,
  parameter int FRAC   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [CH*DW-1:0]           pxl_in,
  input  logic                       wgt_we,
  input  logic [$clog2(9*CH)-1:0]    wgt_addr,
  input  logic [DW-1:0]              wgt_data,
  output logic [DW-1:0]              pxl_out,
  output logic                       valid_out,
  output logic                       frame_done,
  output logic                       wgt_err
);
  localparam int CW     = $clog2(D);
  localparam int SW     = 2*DW + $clog2(9*CH);
  localparam int STAGES = 4;
  localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [CW-1:0]              row_q, col_q;
  logic [STAGES:0]            vld_q;
  logic                       fd_q, werr_q;
  logic [DW-1:0]              pxl_q;
  logic [9*CH-1:0][DW-1:0]    wgt_q;
  logic [CH-1:0][2*DW+3:0]    chsum;
  logic signed [SW-1:0]       xsum_d, xsum_q, sh_d;
  logic                       last_px, fire, wgt_ok;

  assign last_px = (row_q == CW'(D-1)) && (col_q == CW'(D-1));
  assign fire    = valid_in && (row_q >= CW'(2)) && (col_q >= CW'(2)) &&
                   (STRIDE == 1 || (!row_q[0] && !col_q[0]));
  // weights may only change between frames with the datapath drained
  assign wgt_ok  = (row_q == '0) && (col_q == '0) && ~|vld_q[STAGES-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q  <= '0;
      col_q  <= '0;
      vld_q  <= '0;
      fd_q   <= 1'b0;
      werr_q <= 1'b0;
      pxl_q  <= '0;
    end else begin
      if (valid_in) begin
        if (col_q == CW'(D-1)) begin
          col_q <= '0;
          row_q <= (row_q == CW'(D-1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      fd_q   <= valid_in && last_px;
      werr_q <= wgt_we && !wgt_ok;
      vld_q  <= {vld_q[STAGES-1:0], fire};
      if (vld_q[STAGES-1]) begin
        if (sh_d > MAXV)      pxl_q <= MAXV[DW-1:0];
        else if (sh_d < MINV) pxl_q <= MINV[DW-1:0];
        else                  pxl_q <= sh_d[DW-1:0];
      end
    end
  end

  // weight storage deliberately survives reset
  always_ff @(posedge clk) begin
    if (!reset && wgt_we && wgt_ok && int'(wgt_addr) < 9*CH)
      wgt_q[wgt_addr] <= wgt_data;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    conv3x3_ch #(.D(D), .DW(DW), .CW(CW)) u_ch (
      .clk   (clk),
      .acc_i (valid_in),
      .col_i (col_q),
      .pxl_i (pxl_in[c*DW +: DW]),
      .wgt_i (wgt_q[c*9 +: 9]),
      .sum_o (chsum[c])
    );
  end

  always_comb begin
    xsum_d = '0;
    for (int c = 0; c < CH; c++)
      xsum_d = xsum_d + SW'($signed(chsum[c]));
  end

  always_ff @(posedge clk) xsum_q <= xsum_d;

  assign sh_d       = xsum_q >>> FRAC;
  assign pxl_out    = pxl_q;
  assign valid_out  = vld_q[STAGES];
  assign frame_done = fd_q;
  assign wgt_err    = werr_q;
endmodule

// File: tb/tb_conv3x3_merge_param.sv
// Bench for conv3x3_merge_param: two configurations (2ch/stride1/16b and 1ch/stride2/8b)
// checked against a frame-level convolution model plus a constant-frame saturation table.

module tb_conv3x3_merge_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: D=9, DW=16, CH=2, STRIDE=1
  logic        vin_a, we_a, vo_a, fd_a, werr_a;
  logic [31:0] pxl_a;
  logic [4:0]  addr_a;
  logic [15:0] wd_a, po_a;
  // DUT B: D=9, DW=8, CH=1, STRIDE=2
  logic        vin_b, we_b, vo_b, fd_b, werr_b;
  logic [7:0]  pxl_b, wd_b, po_b;
  logic [3:0]  addr_b;

  conv3x3_merge_param #(.D(9), .DW(16), .CH(2), .STRIDE(1), .FRAC(0)) u_a (
    .clk(clk), .reset(rst), .valid_in(vin_a), .pxl_in(pxl_a), .wgt_we(we_a),
    .wgt_addr(addr_a), .wgt_data(wd_a), .pxl_out(po_a), .valid_out(vo_a),
    .frame_done(fd_a), .wgt_err(werr_a));

  conv3x3_merge_param #(.D(9), .DW(8), .CH(1), .STRIDE(2), .FRAC(0)) u_b (
    .clk(clk), .reset(rst), .valid_in(vin_b), .pxl_in(pxl_b), .wgt_we(we_b),
    .wgt_addr(addr_b), .wgt_data(wd_b), .pxl_out(po_b), .valid_out(vo_b),
    .frame_done(fd_b), .wgt_err(werr_b));

  typedef struct { longint w; longint p; longint expv; } vec_t;
  vec_t tbl[9];

  longint pix [2][9][9];
  longint wts [2][9];
  int     acc [9][9];
  int     cyc = 0;
  longint got_v[$];
  int     got_c[$];
  int     fd_cnt = 0, fd_last = 0, werr_cnt = 0;
  int     n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vo_a) begin got_v.push_back(longint'($signed(po_a))); got_c.push_back(cyc); end
    if (vo_b) begin got_v.push_back(longint'($signed(po_b))); got_c.push_back(cyc); end
    if (fd_a || fd_b) begin fd_cnt++; fd_last = cyc; end
    if (werr_a || werr_b) werr_cnt++;
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic clear_mon();
    got_v.delete(); got_c.delete();
    fd_cnt = 0; werr_cnt = 0;
  endtask

  // Convolution straight from the definition, then clamp to the signed DW range.
  function automatic longint ref_px(int ch_n, int row, int col, int dw);
    longint s = 0;
    longint mx = (longint'(1) <<< (dw-1)) - 1;
    for (int c = 0; c < ch_n; c++)
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          s += pix[c][row-2+r][col-2+k] * wts[c][3*r+k];
    if (s > mx) s = mx;
    if (s < -mx-1) s = -mx-1;
    return s;
  endfunction

  task automatic load_w(input int dut, input int ch_n);
    for (int i = 0; i < 9*ch_n; i++) begin
      @(negedge clk);
      if (dut == 0) begin we_a = 1'b1; addr_a = 5'(i); wd_a = 16'(wts[i/9][i%9]); end
      else          begin we_b = 1'b1; addr_b = 4'(i); wd_b = 8'(wts[0][i]); end
    end
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
  endtask

  // Drives one frame in raster order; stop_at < 0 drives all 81 pixels.
  task automatic drive(input int dut, input int gap, input int werr_at, input int stop_at);
    @(negedge clk);
    for (int idx = 0; idx < 81; idx++) begin
      int r = idx / 9;
      int c = idx % 9;
      if (idx == stop_at) break;
      while (gap > 0 && int'($urandom_range(99)) < gap) begin
        vin_a = 1'b0; vin_b = 1'b0;
        @(negedge clk);
      end
      acc[r][c] = cyc + 1;
      if (dut == 0) begin
        vin_a = 1'b1;
        pxl_a = {16'(pix[1][r][c]), 16'(pix[0][r][c])};
        if (idx == werr_at) begin we_a = 1'b1; addr_a = 5'd0; wd_a = 16'd77; end
      end else begin
        vin_b = 1'b1;
        pxl_b = 8'(pix[0][r][c]);
      end
      @(negedge clk);
      vin_a = 1'b0; vin_b = 1'b0;
      if (idx == werr_at) begin
        we_a = 1'b0;
        chk("wgt_err_pulse", longint'(werr_a), 1);
      end
    end
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input int ch_n, input int stride,
                             input int dw, input int exp_werr);
    int k = 0;
    for (int row = 0; row < 9; row++)
      for (int col = 0; col < 9; col++)
        if (row >= 2 && col >= 2 && (row-2) % stride == 0 && (col-2) % stride == 0) begin
          if (k < got_v.size()) begin
            chk({nm, "_value"}, got_v[k], ref_px(ch_n, row, col, dw));
            chk({nm, "_latency"}, longint'(got_c[k] - acc[row][col]), 4);
          end
          k++;
        end
    chk({nm, "_count"}, longint'(got_v.size()), longint'(k));
    chk({nm, "_frame_done_count"}, longint'(fd_cnt), 1);
    chk({nm, "_frame_done_cycle"}, longint'(fd_last), longint'(acc[8][8]));
    chk({nm, "_wgt_err_count"}, longint'(werr_cnt), longint'(exp_werr));
    clear_mon();
  endtask

  task automatic fill(input longint p0, input longint p1, input longint w);
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin pix[0][r][c] = p0; pix[1][r][c] = p1; end
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 9; i++) wts[c][i] = w;
  endtask

  initial begin
    tbl[0] = '{127, 127, 127};
    tbl[1] = '{127, -128, -128};
    tbl[2] = '{1, 1, 9};
    tbl[3] = '{-1, 5, -45};
    tbl[4] = '{2, 7, 126};
    tbl[5] = '{2, 8, 127};
    tbl[6] = '{-2, 8, -128};
    tbl[7] = '{0, 100, 0};
    tbl[8] = '{1, -14, -126};

    rst = 1'b1;
    vin_a = 0; we_a = 0; pxl_a = '0; addr_a = '0; wd_a = '0;
    vin_b = 0; we_b = 0; pxl_b = '0; addr_b = '0; wd_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid_out_a", longint'(vo_a), 0);
    chk("rst_pxl_out_a", longint'(po_a), 0);
    chk("rst_frame_done_a", longint'(fd_a), 0);
    chk("rst_wgt_err_a", longint'(werr_a), 0);
    chk("rst_valid_out_b", longint'(vo_b), 0);
    chk("rst_pxl_out_b", longint'(po_b), 0);
    rst = 1'b0;
    clear_mon();

    // all ones, continuous then 50% valid
    fill(1, 1, 1);
    load_w(0, 2);
    drive(0, 0, -1, -1);
    drain();
    chk("ones_first_value", got_v.size() > 0 ? got_v[0] : -1, 18);
    chk("ones_first_cycle", got_c.size() > 0 ? longint'(got_c[0]) : -1, longint'(acc[2][2] + 4));
    check_frame("ones_cont", 2, 1, 16, 0);
    drive(0, 50, -1, -1);
    drain();
    check_frame("ones_gappy", 2, 1, 16, 0);

    // random pixels and weights, some sums saturate at 16 bits
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 9; i++) wts[c][i] = longint'($urandom_range(200)) - 100;
        for (int r = 0; r < 9; r++)
          for (int k = 0; k < 9; k++) pix[c][r][k] = longint'($urandom_range(200)) - 100;
      end
      load_w(0, 2);
      drive(0, 30, -1, -1);
      drain();
      check_frame("random", 2, 1, 16, 0);
    end

    // rejected mid-frame weight write leaves results untouched
    drive(0, 0, 30, -1);
    drain();
    check_frame("midframe_wgt", 2, 1, 16, 1);

    // reset after pixel 40 discards in-flight windows; weights survive
    drive(0, 0, -1, 41);
    rst = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk);
    chk("midrst_valid_out", longint'(vo_a), 0);
    chk("midrst_pxl_out", longint'(po_a), 0);
    rst = 1'b0;
    drive(0, 0, -1, -1);
    drain();
    check_frame("after_reset", 2, 1, 16, 0);

    // 8-bit constant frames, stride 2
    for (int t = 0; t < 9; t++) begin
      fill(tbl[t].p, 0, tbl[t].w);
      load_w(1, 1);
      drive(1, 0, -1, -1);
      drain();
      chk("tbl_count", longint'(got_v.size()), 16);
      for (int k = 0; k < got_v.size(); k++) chk("tbl_value", got_v[k], tbl[t].expv);
      clear_mon();
    end

    // stride 2, centre tap only, pixel = raster index
    fill(0, 0, 0);
    wts[0][4] = 1;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) pix[0][r][c] = 9*r + c;
    load_w(1, 1);
    drive(1, 0, -1, -1);
    drain();
    chk("stride2_first", got_v.size() > 0 ? got_v[0] : -1, 10);
    chk("stride2_last", got_v.size() > 0 ? got_v[got_v.size()-1] : -1, 70);
    check_frame("stride2", 1, 2, 8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
